mac_scheduler: RTL and testbench



---
 rtl/mac_scheduler.sv | 248 ++++++++++++++++++++++++
 tb/tb_mac_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_scheduler.sv
// Shares one 18x25 signed MAC with a 48-bit accumulator between the HB1, HB2 and
// output FIR stages: arbitrates requests, walks tap addresses, returns tagged sums.
module mac_scheduler #(
    parameter int NTAP0 = 10,
    parameter int NTAP1 = 26,
    parameter int NTAP2 = 34,
    parameter int AW    = 6
) (
    input  logic                 MACCLK,
    input  logic                 RST,
    input  logic [2:0]           req,
    output logic [1:0]           tap_sel,
    output logic [AW-1:0]        tap_addr,
    output logic                 tap_vld,
    input  logic signed [17:0]   a_in,
    input  logic signed [24:0]   b_in,
    output logic signed [47:0]   acc_out,
    output logic                 res_vld,
    output logic [1:0]           res_sel,
    output logic                 busy,
    output logic [2:0]           overrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] LAST0     = AW'(NTAP0 - 1);
    localparam logic [AW-1:0] LAST1     = AW'(NTAP1 - 1);
    localparam logic [AW-1:0] LAST2     = AW'(NTAP2 - 1);

    logic [1:0]          state_q,    state_d;
    logic [2:0]          pending_q,  pending_d;
    logic [2:0]          overrun_q,  overrun_d;
    logic [1:0]          tap_sel_q,  tap_sel_d;
    logic [AW-1:0]       tap_addr_q, tap_addr_d;
    logic                tap_vld_q,  tap_vld_d;
    logic [1:0]          drain_q,    drain_d;
    logic                s1_vld_q,   s1_vld_d;
    logic                s1_first_q, s1_first_d;
    logic                op_vld_q,   op_vld_d;
    logic                op_first_q, op_first_d;
    logic signed [17:0]  a_q,        a_d;
    logic signed [24:0]  b_q,        b_d;
    logic                prod_vld_q,   prod_vld_d;
    logic                prod_first_q, prod_first_d;
    logic signed [42:0]  prod_q,     prod_d;
    logic signed [47:0]  acc_q,      acc_d;
    logic signed [47:0]  acc_out_q,  acc_out_d;
    logic                res_vld_q,  res_vld_d;
    logic [1:0]          res_sel_q,  res_sel_d;
    logic                busy_q,     busy_d;

    logic [2:0]          grant_s;
    logic [1:0]          grant_sel_s;
    logic [AW-1:0]       last_addr_s;
    logic signed [47:0]  prod_ext_s;

    // Fixed-priority arbitration, only evaluated while idle (jobs are non-preemptive).
    always_comb begin
        grant_s     = 3'b000;
        grant_sel_s = 2'd0;
        if (state_q == S_IDLE) begin
            if (pending_q[0]) begin
                grant_s     = 3'b001;
                grant_sel_s = 2'd0;
            end else if (pending_q[1]) begin
                grant_s     = 3'b010;
                grant_sel_s = 2'd1;
            end else if (pending_q[2]) begin
                grant_s     = 3'b100;
                grant_sel_s = 2'd2;
            end else begin
                grant_s     = 3'b000;
                grant_sel_s = 2'd0;
            end
        end else begin
            grant_s     = 3'b000;
            grant_sel_s = 2'd0;
        end
    end

    // Pending and sticky overrun flags; a new request wins over a same-cycle grant.
    always_comb begin
        pending_d = (pending_q & ~grant_s) | req;
        overrun_d = overrun_q | (req & pending_q & ~grant_s);
    end

    // Last tap index of the stage being served.
    always_comb begin
        case (tap_sel_q)
            2'd0:    last_addr_s = LAST0;
            2'd1:    last_addr_s = LAST1;
            2'd2:    last_addr_s = LAST2;
            default: last_addr_s = LAST0;
        endcase
    end

    // MAC pipeline: operand capture, product register, accumulate (first tap loads).
    always_comb begin
        s1_vld_d     = tap_vld_q;
        s1_first_d   = tap_vld_q && (tap_addr_q == ADDR_ZERO);
        op_vld_d     = s1_vld_q;
        op_first_d   = s1_first_q;
        a_d          = a_q;
        b_d          = b_q;
        prod_vld_d   = op_vld_q;
        prod_first_d = op_first_q;
        prod_d       = prod_q;
        acc_d        = acc_q;
        prod_ext_s   = {{5{prod_q[42]}}, prod_q};
        if (s1_vld_q) begin
            a_d = a_in;
            b_d = b_in;
        end else begin
            a_d = a_q;
            b_d = b_q;
        end
        if (op_vld_q) begin
            prod_d = 43'(a_q) * 43'(b_q);
        end else begin
            prod_d = prod_q;
        end
        if (prod_vld_q) begin
            if (prod_first_q) begin
                acc_d = prod_ext_s;
            end else begin
                acc_d = acc_q + prod_ext_s;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Job sequencer: IDLE grant, tap issue, pipeline drain, result publish.
    always_comb begin
        state_d    = state_q;
        tap_sel_d  = tap_sel_q;
        tap_addr_d = tap_addr_q;
        tap_vld_d  = 1'b0;
        drain_d    = drain_q;
        res_vld_d  = 1'b0;
        res_sel_d  = res_sel_q;
        acc_out_d  = acc_out_q;
        case (state_q)
            S_IDLE: begin
                if (|grant_s) begin
                    state_d    = S_ISSUE;
                    tap_sel_d  = grant_sel_s;
                    tap_addr_d = ADDR_ZERO;
                    tap_vld_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (tap_addr_q == last_addr_s) begin
                    state_d   = S_DRAIN;
                    drain_d   = 2'd0;
                    tap_vld_d = 1'b0;
                end else begin
                    tap_addr_d = tap_addr_q + ADDR_ONE;
                    tap_vld_d  = 1'b1;
                end
            end
            S_DRAIN: begin
                // acc_d already carries the last tap's contribution on this edge.
                if (drain_q == 2'd2) begin
                    state_d   = S_DONE;
                    res_vld_d = 1'b1;
                    res_sel_d = tap_sel_q;
                    acc_out_d = acc_d;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, pipeline and output registers.
    always_ff @(posedge MACCLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            pending_q    <= 3'b000;
            overrun_q    <= 3'b000;
            tap_sel_q    <= 2'd0;
            tap_addr_q   <= ADDR_ZERO;
            tap_vld_q    <= 1'b0;
            drain_q      <= 2'd0;
            s1_vld_q     <= 1'b0;
            s1_first_q   <= 1'b0;
            op_vld_q     <= 1'b0;
            op_first_q   <= 1'b0;
            a_q          <= 18'sd0;
            b_q          <= 25'sd0;
            prod_vld_q   <= 1'b0;
            prod_first_q <= 1'b0;
            prod_q       <= 43'sd0;
            acc_q        <= 48'sd0;
            acc_out_q    <= 48'sd0;
            res_vld_q    <= 1'b0;
            res_sel_q    <= 2'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            tap_sel_q    <= tap_sel_d;
            tap_addr_q   <= tap_addr_d;
            tap_vld_q    <= tap_vld_d;
            drain_q      <= drain_d;
            s1_vld_q     <= s1_vld_d;
            s1_first_q   <= s1_first_d;
            op_vld_q     <= op_vld_d;
            op_first_q   <= op_first_d;
            a_q          <= a_d;
            b_q          <= b_d;
            prod_vld_q   <= prod_vld_d;
            prod_first_q <= prod_first_d;
            prod_q       <= prod_d;
            acc_q        <= acc_d;
            acc_out_q    <= acc_out_d;
            res_vld_q    <= res_vld_d;
            res_sel_q    <= res_sel_d;
            busy_q       <= busy_d;
        end
    end

    assign tap_sel  = tap_sel_q;
    assign tap_addr = tap_addr_q;
    assign tap_vld  = tap_vld_q;
    assign acc_out  = acc_out_q;
    assign res_vld  = res_vld_q;
    assign res_sel  = res_sel_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_mac_scheduler.sv
// Directed bench for mac_scheduler: operands are returned one cycle after each
// issued tap, results and flags are checked against hand-computed values.
module tb_mac_scheduler;

    logic               MACCLK;
    logic               RST;
    logic [2:0]         req;
    logic [1:0]         tap_sel;
    logic [5:0]         tap_addr;
    logic               tap_vld;
    logic signed [17:0] a_in;
    logic signed [24:0] b_in;
    logic signed [47:0] acc_out;
    logic               res_vld;
    logic [1:0]         res_sel;
    logic               busy;
    logic [2:0]         overrun;

    int compared   = 0;
    int mismatched = 0;
    int mode       = 0;   // 0: unit operands, 1: ramp (k+1)*(k+2), 2: sign test
    int vld_cnt    = 0;
    int seq_err    = 0;
    int run_idx    = 0;
    int res_cnt    = 0;
    int cyc        = 0;
    logic       prev_vld = 1'b0;
    logic [1:0] run_sel  = 2'd0;
    logic signed [47:0] exp_sign;

    mac_scheduler dut (
        .MACCLK  (MACCLK),
        .RST     (RST),
        .req     (req),
        .tap_sel (tap_sel),
        .tap_addr(tap_addr),
        .tap_vld (tap_vld),
        .a_in    (a_in),
        .b_in    (b_in),
        .acc_out (acc_out),
        .res_vld (res_vld),
        .res_sel (res_sel),
        .busy    (busy),
        .overrun (overrun)
    );

    initial MACCLK = 1'b0;
    always #5 MACCLK = ~MACCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe the current cycle, then return operands for the tap just issued.
    task automatic tick();
        logic       pv;
        logic [5:0] pa;
        pv = tap_vld;
        pa = tap_addr;
        if (tap_vld) begin
            if (!prev_vld) begin
                run_idx = 0;
                run_sel = tap_sel;
            end
            if (tap_addr != 6'(run_idx)) seq_err++;
            run_idx++;
            vld_cnt++;
        end
        prev_vld = tap_vld;
        if (res_vld) res_cnt++;
        @(posedge MACCLK);
        #1;
        if (pv) begin
            case (mode)
                0: begin a_in = 18'sd1; b_in = 25'sd1; end
                1: begin a_in = 18'(int'(pa) + 1); b_in = 25'(int'(pa) + 2); end
                default: begin a_in = 18'sh20000; b_in = 25'sh0FFFFFF; end
            endcase
        end else begin
            a_in = 18'sh15555;
            b_in = 25'sh0AAAAAA;
        end
    endtask

    task automatic pulse(input logic [2:0] r);
        req = r;
        tick();
        req = 3'b000;
    endtask

    task automatic wait_res(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!res_vld && n < 200);
        chk("res_vld_timeout", {63'd0, res_vld}, 64'd1);
    endtask

    initial begin
        RST  = 1'b1;
        req  = 3'b000;
        a_in = 18'sd0;
        b_in = 25'sd0;
        exp_sign = -48'sd74766786232320;
        repeat (3) @(posedge MACCLK);
        #1;
        chk("rst_tap_vld", {63'd0, tap_vld}, 64'd0);
        chk("rst_res_vld", {63'd0, res_vld}, 64'd0);
        chk("rst_acc_out", acc_out, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_overrun", {61'd0, overrun}, 64'd0);
        chk("rst_tap_addr", {58'd0, tap_addr}, 64'd0);
        RST = 1'b0;
        tick();

        // Single stage-0 request, unit operands.
        mode = 0; vld_cnt = 0; seq_err = 0;
        pulse(3'b001);
        wait_res(cyc);
        chk("single_latency", 64'(cyc), 64'd14);
        chk("single_acc", acc_out, 64'd10);
        chk("single_sel", {62'd0, res_sel}, 64'd0);
        chk("single_vld_cnt", 64'(vld_cnt), 64'd10);
        chk("single_addr_seq", 64'(seq_err), 64'd0);
        chk("single_tap_sel", {62'd0, run_sel}, 64'd0);
        chk("done_busy", {63'd0, busy}, 64'd1);
        tick();
        chk("after_busy", {63'd0, busy}, 64'd0);
        chk("after_res_vld", {63'd0, res_vld}, 64'd0);
        chk("hold_acc", acc_out, 64'd10);

        // Ramp operands expose pipeline alignment: sum (k+1)(k+2), k=0..9 = 440.
        mode = 1;
        pulse(3'b001);
        wait_res(cyc);
        chk("ramp0_acc", acc_out, 64'd440);

        // Simultaneous requests are served 0, 1, 2.
        mode = 0; vld_cnt = 0; seq_err = 0;
        pulse(3'b111);
        wait_res(cyc);
        chk("sim0_sel", {62'd0, res_sel}, 64'd0);
        chk("sim0_acc", acc_out, 64'd10);
        wait_res(cyc);
        chk("sim1_sel", {62'd0, res_sel}, 64'd1);
        chk("sim1_acc", acc_out, 64'd26);
        wait_res(cyc);
        chk("sim2_sel", {62'd0, res_sel}, 64'd2);
        chk("sim2_acc", acc_out, 64'd34);
        chk("sim_vld_cnt", 64'(vld_cnt), 64'd70);
        chk("sim_addr_seq", 64'(seq_err), 64'd0);
        chk("sim_overrun", {61'd0, overrun}, 64'd0);
        tick();

        // Full-scale negative sample times max coefficient on all 34 taps.
        mode = 2;
        pulse(3'b100);
        wait_res(cyc);
        chk("sign_sel", {62'd0, res_sel}, 64'd2);
        chk("sign_acc", acc_out, exp_sign);
        tick();

        // Request in the grant cycle re-arms pending without overrun.
        mode = 0;
        pulse(3'b001);
        pulse(3'b001);
        wait_res(cyc);
        chk("same_first_sel", {62'd0, res_sel}, 64'd0);
        wait_res(cyc);
        chk("same_second_sel", {62'd0, res_sel}, 64'd0);
        chk("same_second_acc", acc_out, 64'd10);
        chk("same_overrun", {61'd0, overrun}, 64'd0);
        tick();

        // Two stage-0 requests during a stage-1 job: one is lost, overrun[0] sticks.
        pulse(3'b010);
        repeat (5) tick();
        pulse(3'b001);
        repeat (2) tick();
        pulse(3'b001);
        chk("ovr_set", {61'd0, overrun}, 64'd1);
        wait_res(cyc);
        chk("ovr_job1_sel", {62'd0, res_sel}, 64'd1);
        chk("ovr_job1_acc", acc_out, 64'd26);
        wait_res(cyc);
        chk("ovr_job0_sel", {62'd0, res_sel}, 64'd0);
        chk("ovr_job0_acc", acc_out, 64'd10);
        tick();
        res_cnt = 0;
        repeat (40) tick();
        chk("ovr_no_extra", 64'(res_cnt), 64'd0);
        chk("ovr_sticky", {61'd0, overrun}, 64'd1);

        // Reset during stage-1 tap 12 with a stage-0 request pending.
        pulse(3'b010);
        repeat (4) tick();
        pulse(3'b001);
        cyc = 0;
        while (!(tap_vld && tap_addr == 6'd12) && cyc < 60) begin
            tick();
            cyc++;
        end
        chk("rstmid_reach_tap12", {58'd0, tap_addr}, 64'd12);
        RST = 1'b1;
        #1;
        chk("rstmid_tap_vld", {63'd0, tap_vld}, 64'd0);
        chk("rstmid_tap_addr", {58'd0, tap_addr}, 64'd0);
        chk("rstmid_tap_sel", {62'd0, tap_sel}, 64'd0);
        chk("rstmid_acc", acc_out, 64'd0);
        chk("rstmid_busy", {63'd0, busy}, 64'd0);
        chk("rstmid_overrun", {61'd0, overrun}, 64'd0);
        chk("rstmid_res_sel", {62'd0, res_sel}, 64'd0);
        tick();
        RST = 1'b0;
        res_cnt = 0;
        repeat (50) tick();
        chk("rstmid_no_result", 64'(res_cnt), 64'd0);
        chk("rstmid_idle", {63'd0, busy}, 64'd0);

        // Fresh stage-1 job after reset: sum (k+1)(k+2), k=0..25 = 6552.
        mode = 1;
        pulse(3'b010);
        wait_res(cyc);
        chk("post_rst_latency", 64'(cyc), 64'd30);
        chk("post_rst_sel", {62'd0, res_sel}, 64'd1);
        chk("post_rst_acc", acc_out, 64'd6552);
        chk("post_rst_overrun", {61'd0, overrun}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
